// File: rtl/chip8_pkg.sv
// chip8_pkg: shared types and default constants for the CHIP-8 sound generator.
// Optional feature macro: CHIP8_SOUND_TAIL_EN (adds the TAIL state in chip8_sound_gen).
package chip8_pkg;

    typedef enum logic [1:0] {
        SILENT = 2'd0,
        TONE   = 2'd1,
        TAIL   = 2'd2
    } snd_state_t;

    localparam int                  SND_W           = 16;
    localparam int                  SND_SAMPLE_DIV  = 1042;
    localparam int                  SND_HALF_PERIOD = 55;
    localparam logic signed [15:0]  SND_AMPLITUDE   = 16'sd8000;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chip8_tick_div.sv
// chip8_tick_div: free-running divider, one-cycle o_tick every DIV clk50 cycles.
module chip8_tick_div
    import chip8_pkg::*;
#(
    parameter int DIV = SND_SAMPLE_DIV
) (
    input  logic clk50,
    input  logic reset,
    output logic o_tick
);

    localparam int           W    = cnt_w(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] r_div_cnt;

    assign o_tick = (r_div_cnt == LAST);

    // Count 0..DIV-1 and wrap on the tick cycle.
    always_ff @(posedge clk50) begin
        if (reset)
            r_div_cnt <= '0;
        else if (o_tick)
            r_div_cnt <= '0;
        else
            r_div_cnt <= r_div_cnt + 1'b1;
    end

endmodule

// File: rtl/chip8_sound_gen.sv
// chip8_sound_gen: square-wave PCM generator gated by the CHIP-8 sound timer.
// Define CHIP8_SOUND_TAIL_EN to let the tone finish its low half-cycle before
// going silent (TAIL state); without it the tone stops on the next tick.
module chip8_sound_gen
    import chip8_pkg::*;
#(
    parameter int                       SAMPLE_DIV  = SND_SAMPLE_DIV,
    parameter int                       HALF_PERIOD = SND_HALF_PERIOD,
    parameter logic signed [SND_W-1:0]  AMPLITUDE   = SND_AMPLITUDE
) (
    input  logic                     clk50,
    input  logic                     reset,
    input  logic [7:0]               st_val,
    input  logic                     sample_ready,
    output logic                     sample_valid,
    output logic signed [SND_W-1:0]  sample,
    output logic                     tone_active,
    output logic [7:0]               overrun_cnt
);

    localparam int            PW      = cnt_w(HALF_PERIOD);
    localparam logic [PW-1:0] PH_LAST = PW'(HALF_PERIOD - 1);

    logic                     w_tick;
    logic                     w_timer_on;
    logic                     w_half_end;
    snd_state_t               r_state,     w_state_nxt;
    logic [PW-1:0]            r_phase_cnt, w_phase_cnt_nxt;
    logic                     r_phase,     w_phase_nxt;
    logic signed [SND_W-1:0]  w_new_sample;
    logic                     r_valid;
    logic signed [SND_W-1:0]  r_sample;
    logic [7:0]               r_overrun;

    chip8_tick_div #(.DIV(SAMPLE_DIV)) u_div (
        .clk50  (clk50),
        .reset  (reset),
        .o_tick (w_tick)
    );

    assign w_timer_on = (st_val != 8'd0);
    assign w_half_end = (r_phase_cnt == PH_LAST);

    // Next state, phase advance and the sample for this tick (from the pre-transition state).
    always_comb begin
        w_state_nxt     = r_state;
        w_phase_cnt_nxt = r_phase_cnt;
        w_phase_nxt     = r_phase;
        w_new_sample    = '0;
        if (r_state != SILENT) begin
            w_new_sample = r_phase ? AMPLITUDE : -AMPLITUDE;
            if (w_half_end) begin
                w_phase_cnt_nxt = '0;
                w_phase_nxt     = ~r_phase;
            end else begin
                w_phase_cnt_nxt = r_phase_cnt + 1'b1;
            end
        end
        case (r_state)
            SILENT: begin
                if (w_timer_on) begin
                    w_state_nxt     = TONE;
                    w_phase_cnt_nxt = '0;
                    w_phase_nxt     = 1'b1;
                end
            end
            TONE: begin
                if (!w_timer_on) begin
`ifdef CHIP8_SOUND_TAIL_EN
                    w_state_nxt = TAIL;
`else
                    w_state_nxt = SILENT;
`endif
                end
            end
`ifdef CHIP8_SOUND_TAIL_EN
            TAIL: begin
                // Re-trigger keeps the running phase; otherwise stop at the end of a low half.
                if (w_timer_on)
                    w_state_nxt = TONE;
                else if (!r_phase && w_half_end)
                    w_state_nxt = SILENT;
            end
`endif
            default: w_state_nxt = SILENT;
        endcase
    end

    // Tone state and phase only move on sample ticks.
    always_ff @(posedge clk50) begin
        if (reset) begin
            r_state     <= SILENT;
            r_phase_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (w_tick) begin
            r_state     <= w_state_nxt;
            r_phase_cnt <= w_phase_cnt_nxt;
            r_phase     <= w_phase_nxt;
        end
    end

    // Output handshake: load on tick when the slot is free or being drained, else count the drop.
    always_ff @(posedge clk50) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_sample  <= '0;
            r_overrun <= '0;
        end else if (w_tick) begin
            if (!r_valid || sample_ready) begin
                r_sample <= w_new_sample;
                r_valid  <= 1'b1;
            end else if (r_overrun != 8'hFF) begin
                r_overrun <= r_overrun + 1'b1;
            end
        end else if (r_valid && sample_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign sample_valid = r_valid;
    assign sample       = r_sample;
    assign overrun_cnt  = r_overrun;
    assign tone_active  = (r_state != SILENT);

endmodule
